// File: rtl/aes_enc_iter_if.sv
// Handshake bundle for the iterative AES encryptor: plaintext/key request side
// and registered ciphertext response side, plus a busy indication.
interface aes_enc_iter_if #(
  parameter int KEY_LEN = 128
);
  logic               in_valid;
  logic               in_ready;
  logic [127:0]       in_text;
  logic [KEY_LEN-1:0] in_key;
  logic               out_valid;
  logic               out_ready;
  logic [127:0]       out_data;
  logic               busy;

  modport master (
    output in_valid, in_text, in_key, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_text, in_key, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_enc_iter.sv
// Iterative AES-128/256 encryptor: one round per clock, on-the-fly key expansion,
// registered valid/ready result port. Includes the shared byte S-box.
module sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX[in_byte];
endmodule

module aes_enc_iter #(
  parameter int KEY_LEN = 128
) (
  input logic           clk,
  input logic           rst_n,
  aes_enc_iter_if.slave bus
);
  localparam int         NR       = (KEY_LEN == 256) ? 14 : 10;
  localparam logic [3:0] LAST_RND = 4'(NR);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [3:0]         rnd_q, rnd_d;
  logic [127:0]       st_q, st_d;
  logic [KEY_LEN-1:0] key_q, key_d;
  logic [7:0]         rcon_q, rcon_d;
  logic               out_valid_q, out_valid_d;
  logic [127:0]       out_data_q, out_data_d;
  logic               busy_q, busy_d;
  logic               in_ready;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes on the current state, byte i at [127-8i -: 8]
  logic [127:0] sb;
  for (genvar i = 0; i < 16; i++) begin : g_data_sbox
    sbox u_sbox (.in_byte(st_q[127-8*i -: 8]), .out_byte(sb[127-8*i -: 8]));
  end

  // Key schedule step; the newest word is always key_q[31:0] and the group it
  // replaces is the top 128 bits of the window, for both key sizes.
  logic         rot;
  logic [31:0]  ks_in, ks_sub, ks_f;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] old_grp, new_grp, rk;
  logic [KEY_LEN-1:0] key_next;

  assign rot     = (KEY_LEN == 128) || rnd_q[0];
  assign ks_in   = rot ? {key_q[23:0], key_q[31:24]} : key_q[31:0];
  for (genvar j = 0; j < 4; j++) begin : g_key_sbox
    sbox u_sbox (.in_byte(ks_in[31-8*j -: 8]), .out_byte(ks_sub[31-8*j -: 8]));
  end
  assign ks_f    = ks_sub ^ (rot ? {rcon_q, 24'h0} : 32'h0);
  assign old_grp = key_q[KEY_LEN-1 -: 128];
  assign n0      = old_grp[127:96] ^ ks_f;
  assign n1      = old_grp[95:64]  ^ n0;
  assign n2      = old_grp[63:32]  ^ n1;
  assign n3      = old_grp[31:0]   ^ n2;
  assign new_grp = {n0, n1, n2, n3};

  if (KEY_LEN == 128) begin : g_k128
    assign rk       = new_grp;
    assign key_next = new_grp;
  end else if (KEY_LEN == 256) begin : g_k256
    // Window is {rk[r-1], rk[r]}: this round's key is already registered.
    assign rk       = key_q[127:0];
    assign key_next = {key_q[127:0], new_grp};
  end else begin : g_bad_key_len
    $error("aes_enc_iter: KEY_LEN must be 128 or 256");
  end

  logic [127:0] sr, mc, round_out;
  logic [7:0]   a0, a1, a2, a3;

  always_comb begin
    sr = '0;
    mc = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[127-32*c -: 8];
      a1 = sr[119-32*c -: 8];
      a2 = sr[111-32*c -: 8];
      a3 = sr[103-32*c -: 8];
      mc[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

  assign round_out = ((rnd_q == LAST_RND) ? sr : mc) ^ rk;
  assign in_ready  = (state_q == IDLE) && (!out_valid_q || bus.out_ready);

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block infers a latch.
    state_d     = state_q;
    rnd_d       = rnd_q;
    st_d        = st_q;
    key_d       = key_q;
    rcon_d      = rcon_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready) begin
          st_d    = bus.in_text ^ bus.in_key[KEY_LEN-1 -: 128];
          key_d   = bus.in_key;
          rcon_d  = 8'h01;
          rnd_d   = 4'd1;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        st_d  = round_out;
        key_d = key_next;
        rnd_d = rnd_q + 4'd1;
        if (rot) rcon_d = xtime(rcon_q);
        if (rnd_q == LAST_RND) begin
          rnd_d       = '0;
          busy_d      = 1'b0;
          out_data_d  = round_out;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use <= so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rnd_q       <= '0;
      st_q        <= '0;
      key_q       <= '0;
      rcon_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      st_q        <= st_d;
      key_q       <= key_d;
      rcon_q      <= rcon_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_aes_enc_iter.sv
// Directed FIPS-197 vectors for aes_enc_iter (AES-128 and AES-256 instances),
// covering latency, back-to-back, backpressure and mid-run reset.
module tb_aes_enc_iter;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   lat;
  int   rdy_hi;
  int   bad;

  aes_enc_iter_if #(.KEY_LEN(128)) if128 ();
  aes_enc_iter_if #(.KEY_LEN(256)) if256 ();

  aes_enc_iter #(.KEY_LEN(128)) u_dut128 (.clk(clk), .rst_n(rst_n), .bus(if128));
  aes_enc_iter #(.KEY_LEN(256)) u_dut256 (.clk(clk), .rst_n(rst_n), .bus(if256));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called at the negedge just after the accept edge; returns cycles to out_valid.
  task automatic wait_out128(output int l, output int r);
    l = -1;
    r = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (if128.out_valid) begin
        l = k;
        break;
      end
      if (if128.in_ready) r++;
    end
  endtask

  task automatic wait_out256(output int l, output int r);
    l = -1;
    r = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (if256.out_valid) begin
        l = k;
        break;
      end
      if (if256.in_ready) r++;
    end
  endtask

  task automatic run128(input string tag, input logic [127:0] pt, input logic [127:0] key,
                        input logic [127:0] ct);
    if128.in_valid = 1'b1;
    if128.in_text  = pt;
    if128.in_key   = key;
    check({tag, "_in_ready_idle"}, 128'(if128.in_ready), 128'd1);
    @(negedge clk);
    if128.in_valid = 1'b0;
    check({tag, "_busy_run"}, 128'(if128.busy), 128'd1);
    wait_out128(lat, rdy_hi);
    check({tag, "_latency"}, 128'(lat), 128'd10);
    check({tag, "_in_ready_run"}, 128'(rdy_hi), 128'd0);
    check({tag, "_data"}, if128.out_data, ct);
    check({tag, "_busy_done"}, 128'(if128.busy), 128'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    if128.in_valid = 1'b0; if128.in_text = '0; if128.in_key = '0; if128.out_ready = 1'b1;
    if256.in_valid = 1'b0; if256.in_text = '0; if256.in_key = '0; if256.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    check("rst128_in_ready",  128'(if128.in_ready),  128'd1);
    check("rst128_out_valid", 128'(if128.out_valid), 128'd0);
    check("rst128_out_data",  if128.out_data,        128'd0);
    check("rst128_busy",      128'(if128.busy),      128'd0);
    check("rst256_in_ready",  128'(if256.in_ready),  128'd1);
    check("rst256_out_valid", 128'(if256.out_valid), 128'd0);
    check("rst256_out_data",  if256.out_data,        128'd0);
    check("rst256_busy",      128'(if256.busy),      128'd0);

    // First accept lands on the first edge after release.
    rst_n = 1'b1;
    run128("appb", PT_B, KEY_B, CT_B);
    run128("c1", PT_C, KEY_C1, CT_C1);

    // AES-256, FIPS-197 C.3
    if256.in_valid = 1'b1;
    if256.in_text  = PT_C;
    if256.in_key   = KEY_C3;
    @(negedge clk);
    if256.in_valid = 1'b0;
    check("c3_busy_run", 128'(if256.busy), 128'd1);
    wait_out256(lat, rdy_hi);
    check("c3_latency", 128'(lat), 128'd14);
    check("c3_in_ready_run", 128'(rdy_hi), 128'd0);
    check("c3_data", if256.out_data, CT_C3);

    // Back-to-back with in_valid held: second accept 11 edges after the first.
    if128.in_valid = 1'b1;
    if128.in_text  = PT_B;
    if128.in_key   = KEY_B;
    @(negedge clk);
    if128.in_text  = PT_C;
    if128.in_key   = KEY_C1;
    wait_out128(lat, rdy_hi);
    check("b2b_first_latency", 128'(lat), 128'd10);
    check("b2b_in_ready_run", 128'(rdy_hi), 128'd0);
    check("b2b_first_data", if128.out_data, CT_B);
    check("b2b_in_ready_at_result", 128'(if128.in_ready), 128'd1);
    @(negedge clk);
    if128.in_valid = 1'b0;
    check("b2b_second_accepted", 128'(if128.busy), 128'd1);
    check("b2b_out_valid_consumed", 128'(if128.out_valid), 128'd0);
    wait_out128(lat, rdy_hi);
    check("b2b_second_latency", 128'(lat), 128'd10);
    check("b2b_second_data", if128.out_data, CT_C1);

    // Backpressure: drain the pending result, then stall the next one.
    @(negedge clk);
    if128.out_ready = 1'b0;
    if128.in_valid  = 1'b1;
    if128.in_text   = PT_B;
    if128.in_key    = KEY_B;
    @(negedge clk);
    if128.in_text = PT_C;
    if128.in_key  = KEY_C1;
    wait_out128(lat, rdy_hi);
    check("bp_latency", 128'(lat), 128'd10);
    check("bp_data", if128.out_data, CT_B);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!if128.out_valid || if128.out_data !== CT_B || if128.in_ready || if128.busy) bad++;
    end
    check("bp_stall_held", 128'(bad), 128'd0);
    check("bp_in_ready_stalled", 128'(if128.in_ready), 128'd0);
    if128.out_ready = 1'b1;
    #1;
    check("bp_in_ready_comb", 128'(if128.in_ready), 128'd1);
    @(negedge clk);
    if128.in_valid = 1'b0;
    check("bp_consumed", 128'(if128.out_valid), 128'd0);
    check("bp_second_accepted", 128'(if128.busy), 128'd1);
    wait_out128(lat, rdy_hi);
    check("bp_second_latency", 128'(lat), 128'd10);
    check("bp_second_data", if128.out_data, CT_C1);

    // Mid-run reset at round 5, then a fresh run.
    if128.in_valid = 1'b1;
    if128.in_text  = PT_B;
    if128.in_key   = KEY_B;
    @(negedge clk);
    if128.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mr_busy_before", 128'(if128.busy), 128'd1);
    rst_n = 1'b0;
    #1;
    check("mr_out_valid", 128'(if128.out_valid), 128'd0);
    check("mr_busy",      128'(if128.busy),      128'd0);
    check("mr_out_data",  if128.out_data,        128'd0);
    check("mr_in_ready",  128'(if128.in_ready),  128'd1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if128.out_valid || if128.busy) bad++;
    end
    check("mr_no_pulse", 128'(bad), 128'd0);
    rst_n = 1'b1;
    run128("mr_fresh", PT_B, KEY_B, CT_B);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
